crypto_wallet_gpio_in_conditioner: RTL

- Pin-side input conditioning stage for the 2-bit GPIO0[33:32] bidirectional pins.
- Synchronises and debounces the raw pad levels, then presents a clean level to the downstream GPIO PIO data-in path.
- Captures qualified rising/falling edges and raises a maskable interrupt to the Nios II.
- Register access is an Avalon-MM slave with the same addressing and timing as the GPIO PIO slaves, so firmware uses one access pattern for both.

---
 rtl/crypto_wallet_gpio_in_conditioner.sv | 106 ++++++++++
 1 files changed

// File: rtl/crypto_wallet_gpio_in_conditioner.sv
// GPIO pin conditioner: 2-flop sync, per-bit debounce, qualified edge capture, and a maskable irq.
// Avalon-MM slave with registered readdata (1-cycle read latency). Writes take effect at the strobe edge.
module crypto_wallet_gpio_in_conditioner #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] level_out,
  output logic             irq
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       LP_ADDR_DATA = 2'd0;
  localparam logic [1:0]       LP_ADDR_MASK = 2'd1;
  localparam logic [1:0]       LP_ADDR_CAP  = 2'd2;
  localparam logic [1:0]       LP_ADDR_CFG  = 2'd3;

  logic [WIDTH-1:0]   r_sync1;
  logic [WIDTH-1:0]   r_sync2;
  logic [WIDTH-1:0]   r_stable;
  logic [WIDTH-1:0]   r_stable_d;
  logic [CNT_W-1:0]   r_cnt [WIDTH];
  logic [WIDTH-1:0]   r_edge_capture;
  logic [WIDTH-1:0]   r_irq_mask;
  logic [2*WIDTH-1:0] r_edge_cfg;
  logic [31:0]        r_readdata;

  logic               w_wr;
  logic [WIDTH-1:0]   w_rise;
  logic [WIDTH-1:0]   w_fall;
  logic [WIDTH-1:0]   w_event;
  logic [WIDTH-1:0]   w_w1c;
  logic [31:0]        w_rdata;
  logic               w_unused_wdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_unused_wdata = ^writedata[31:2*WIDTH];

  // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= pin_in;
      r_sync2 <= r_sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_CNT_MAX) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_rise  = r_stable & ~r_stable_d;
  assign w_fall  = ~r_stable & r_stable_d;
  assign w_event = (w_rise & r_edge_cfg[WIDTH-1:0]) | (w_fall & r_edge_cfg[2*WIDTH-1:WIDTH]);
  assign w_w1c   = (w_wr && address == LP_ADDR_CAP) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    w_rdata = '0;
    case (address)
      LP_ADDR_DATA: w_rdata[WIDTH-1:0]   = r_stable;
      LP_ADDR_MASK: w_rdata[WIDTH-1:0]   = r_irq_mask;
      LP_ADDR_CAP:  w_rdata[WIDTH-1:0]   = r_edge_capture;
      default:      w_rdata[2*WIDTH-1:0] = r_edge_cfg;
    endcase
  end

  // A new event on the same edge as a W1C keeps the capture bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable_d     <= '0;
      r_edge_capture <= '0;
      r_irq_mask     <= '0;
      r_edge_cfg     <= '0;
      r_readdata     <= '0;
    end else begin
      r_stable_d     <= r_stable;
      r_edge_capture <= (r_edge_capture & ~w_w1c) | w_event;
      r_readdata     <= w_rdata;
      if (w_wr && address == LP_ADDR_MASK) r_irq_mask <= writedata[WIDTH-1:0];
      if (w_wr && address == LP_ADDR_CFG)  r_edge_cfg <= writedata[2*WIDTH-1:0];
    end
  end

  assign readdata  = r_readdata;
  assign level_out = r_stable;
  assign irq       = |(r_edge_capture & r_irq_mask);

endmodule
